// File: rtl/sdram_req_bridge.sv
// Bridges the tetris drawing FSM to the SDRAM controller: a write FIFO, a one-entry read slot,
// and one req/ack transaction at a time. Define SDRAM_BRIDGE_RD_PRIO_EN to let reads beat queued writes.
module sdram_req_bridge #(
  parameter int WQ_DEPTH = 4,
  parameter int AW       = 16,
  parameter int DW       = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          write,
  input  logic [AW-1:0] writeaddr,
  input  logic [DW-1:0] writedata,
  output logic          wr_full,
  input  logic          read,
  input  logic [AW-1:0] readaddr,
  output logic          rd_empty,
  output logic [DW-1:0] readdata,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ack,
  input  logic          mem_rvalid,
  input  logic [DW-1:0] mem_rdata,
  output logic [1:0]    err
);
  localparam int PW = $clog2(WQ_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, ISSUE_W, ISSUE_R, WAIT_RD} state_t;
  state_t state, state_n;

  logic [AW-1:0] wq_addr [WQ_DEPTH];
  logic [DW-1:0] wq_data [WQ_DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic [CW-1:0] count, count_n;
  logic          push, pop;
  logic          rd_pend;
  logic [AW-1:0] rd_addr;

  // wr_full is the registered flag, so a push in the same cycle as a pop while full is still rejected
  assign push    = write && !wr_full;
  assign pop     = (state == ISSUE_W) && mem_ack;
  assign count_n = count + CW'(push) - CW'(pop);

  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
`ifdef SDRAM_BRIDGE_RD_PRIO_EN
        if (rd_pend)             state_n = ISSUE_R;
        else if (count != '0)    state_n = ISSUE_W;
`else
        if (count != '0)         state_n = ISSUE_W;
        else if (rd_pend)        state_n = ISSUE_R;
`endif
      end
      ISSUE_W: if (mem_ack)    state_n = IDLE;
      ISSUE_R: if (mem_ack)    state_n = WAIT_RD;
      WAIT_RD: if (mem_rvalid) state_n = IDLE;
      default:                 state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      wq_addr[wptr] <= writeaddr;
      wq_data[wptr] <= writedata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      wr_full   <= 1'b0;
      rd_pend   <= 1'b0;
      rd_addr   <= '0;
      rd_empty  <= 1'b1;
      readdata  <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      err       <= '0;
    end else begin
      state   <= state_n;
      count   <= count_n;
      wr_full <= (count_n == CW'(WQ_DEPTH));
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
      if (write && wr_full) err[0] <= 1'b1;

      // rd_pend covers both queued and in-flight reads, so a second read is dropped either way
      if (read) begin
        if (rd_pend) err[1] <= 1'b1;
        else begin
          rd_addr  <= readaddr;
          rd_pend  <= 1'b1;
          rd_empty <= 1'b1;
        end
      end
      if (state == WAIT_RD && mem_rvalid) begin
        readdata <= mem_rdata;
        rd_pend  <= 1'b0;
        rd_empty <= 1'b0;
      end

      // bus is loaded only on leaving IDLE and held until the ack edge
      if (state == IDLE && state_n == ISSUE_W) begin
        mem_req   <= 1'b1;
        mem_we    <= 1'b1;
        mem_addr  <= wq_addr[rptr];
        mem_wdata <= wq_data[rptr];
      end else if (state == IDLE && state_n == ISSUE_R) begin
        mem_req  <= 1'b1;
        mem_we   <= 1'b0;
        mem_addr <= rd_addr;
      end else if ((state == ISSUE_W || state == ISSUE_R) && mem_ack) begin
        mem_req <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_sdram_req_bridge.sv
// Directed bench for sdram_req_bridge: reset, FIFO fill/drain, read round trip,
// arbitration order, duplicate read and reset mid-transaction.
module tb_sdram_req_bridge;
  localparam int AW = 16;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset, write, read, mem_ack, mem_rvalid;
  logic [AW-1:0] writeaddr, readaddr;
  logic [DW-1:0] writedata, mem_rdata;
  logic          wr_full, rd_empty, mem_req, mem_we;
  logic [DW-1:0] readdata, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic [1:0]    err;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [AW:0] req_log [$];
  logic        req_prev = 1'b0;

  sdram_req_bridge #(.WQ_DEPTH(4), .AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset), .write(write), .writeaddr(writeaddr), .writedata(writedata),
    .wr_full(wr_full), .read(read), .readaddr(readaddr), .rd_empty(rd_empty), .readdata(readdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .err(err)
  );

  always #5 clk = ~clk;

  // log {we, addr} at every rising mem_req
  always @(negedge clk) begin
    if (mem_req && !req_prev) req_log.push_back({mem_we, mem_addr});
    req_prev = mem_req;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; write = 1'b0; read = 1'b0; mem_ack = 1'b0; mem_rvalid = 1'b0;
    writeaddr = '0; writedata = '0; readaddr = '0; mem_rdata = '0;
    tick();
    reset = 1'b0;
  endtask

  task automatic wait_req(output bit ok);
    int n = 0;
    while (!mem_req && n < 20) begin
      tick();
      n++;
    end
    ok = mem_req;
  endtask

  task automatic test_reset();
    do_reset();
    total_cnt++;
    if ({wr_full, rd_empty, readdata, mem_req, mem_we, mem_addr, mem_wdata, err} !==
        {1'b0, 1'b1, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 2'b00})
      $display("FAIL reset_vals: got full=%b empty=%b rdata=%h req=%b we=%b addr=%h wd=%h err=%b",
               wr_full, rd_empty, readdata, mem_req, mem_we, mem_addr, mem_wdata, err);
    else pass_cnt++;
  endtask

  task automatic test_fifo_fill();
    bit ok;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      write = 1'b1; writeaddr = AW'(i); writedata = DW'(i);
      tick();
      if (i == 0) begin
        total_cnt++;
        if (mem_req !== 1'b0) $display("FAIL fill_req_n1: got %b want 0", mem_req); else pass_cnt++;
      end
      if (i == 1) begin
        total_cnt++;
        if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b1, 16'h0000})
          $display("FAIL fill_req_n2: got req=%b we=%b addr=%h want 1 1 0000", mem_req, mem_we, mem_addr);
        else pass_cnt++;
      end
    end
    total_cnt++;
    if (wr_full !== 1'b1) $display("FAIL fill_full: got %b want 1", wr_full); else pass_cnt++;
    total_cnt++;
    if (err !== 2'b00) $display("FAIL fill_err_clean: got %b want 00", err); else pass_cnt++;
    writeaddr = 16'h0099; writedata = 16'h0099;
    tick();
    write = 1'b0;
    total_cnt++;
    if (err !== 2'b01) $display("FAIL fill_err0: got %b want 01", err); else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      wait_req(ok);
      total_cnt++;
      if (!ok || mem_addr !== AW'(i) || mem_wdata !== DW'(i) || mem_we !== 1'b1)
        $display("FAIL drain_%0d: got req=%b addr=%h wd=%h we=%b want addr=wd=%0d we=1",
                 i, mem_req, mem_addr, mem_wdata, mem_we, i);
      else pass_cnt++;
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      total_cnt++;
      if (mem_req !== 1'b0) $display("FAIL drain_req_low_%0d: got %b want 0", i, mem_req); else pass_cnt++;
      if (i == 0) begin
        total_cnt++;
        if (wr_full !== 1'b0) $display("FAIL drain_full_drop: got %b want 0", wr_full); else pass_cnt++;
      end
    end
    repeat (3) tick();
    total_cnt++;
    if (mem_req !== 1'b0) $display("FAIL drain_done_idle: got %b want 0", mem_req); else pass_cnt++;
  endtask

  task automatic test_read_round_trip();
    do_reset();
    read = 1'b1; readaddr = 16'h0003;
    tick();
    read = 1'b0;
    total_cnt++;
    if ({rd_empty, mem_req} !== 2'b10) $display("FAIL rd_n1: got empty=%b req=%b want 1 0", rd_empty, mem_req);
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, 16'h0003})
      $display("FAIL rd_issue: got req=%b we=%b addr=%h want 1 0 0003", mem_req, mem_we, mem_addr);
    else pass_cnt++;
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    total_cnt++;
    if (mem_req !== 1'b0) $display("FAIL rd_req_low: got %b want 0", mem_req); else pass_cnt++;
    tick();
    tick();
    total_cnt++;
    if ({rd_empty, readdata} !== {1'b1, 16'h0000})
      $display("FAIL rd_before_rvalid: got empty=%b data=%h want 1 0000", rd_empty, readdata);
    else pass_cnt++;
    mem_rvalid = 1'b1; mem_rdata = 16'h0003;
    tick();
    mem_rvalid = 1'b0; mem_rdata = 16'h0000;
    total_cnt++;
    if ({rd_empty, readdata} !== {1'b0, 16'h0003})
      $display("FAIL rd_data: got empty=%b data=%h want 0 0003", rd_empty, readdata);
    else pass_cnt++;
  endtask

  task automatic test_arbitration();
    bit ok;
    int base;
    logic [AW:0] exp [3];
`ifdef SDRAM_BRIDGE_RD_PRIO_EN
    exp[0] = {1'b0, 16'h0020}; exp[1] = {1'b1, 16'h0010}; exp[2] = {1'b1, 16'h0011};
`else
    exp[0] = {1'b1, 16'h0010}; exp[1] = {1'b1, 16'h0011}; exp[2] = {1'b0, 16'h0020};
`endif
    do_reset();
    base = req_log.size();
    write = 1'b1; writeaddr = 16'h0010; writedata = 16'h1111;
    read = 1'b1; readaddr = 16'h0020;
    tick();
    read = 1'b0; writeaddr = 16'h0011; writedata = 16'h2222;
    tick();
    write = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bit is_rd;
      wait_req(ok);
      total_cnt++;
      if (!ok) $display("FAIL arb_timeout_%0d: got req=0 want 1", i); else pass_cnt++;
      is_rd = !mem_we;
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      if (is_rd) begin
        tick();
        mem_rvalid = 1'b1; mem_rdata = 16'h5A5A;
        tick();
        mem_rvalid = 1'b0;
      end
    end
    tick();
    for (int i = 0; i < 3; i++) begin
      total_cnt++;
      if (req_log.size() <= base + i || req_log[base + i] !== exp[i])
        $display("FAIL arb_order_%0d: got %h want %h", i,
                 (req_log.size() > base + i) ? req_log[base + i] : 17'h1ffff, exp[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_duplicate_read();
    int base;
    do_reset();
    base = req_log.size();
    read = 1'b1; readaddr = 16'h0005;
    tick();
    read = 1'b0;
    tick();
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    read = 1'b1; readaddr = 16'h0007;
    tick();
    read = 1'b0;
    total_cnt++;
    if (err !== 2'b10) $display("FAIL dup_err1: got %b want 10", err); else pass_cnt++;
    mem_rvalid = 1'b1; mem_rdata = 16'hABCD;
    tick();
    mem_rvalid = 1'b0;
    repeat (5) tick();
    total_cnt++;
    if ({rd_empty, readdata} !== {1'b0, 16'hABCD})
      $display("FAIL dup_data: got empty=%b data=%h want 0 abcd", rd_empty, readdata);
    else pass_cnt++;
    total_cnt++;
    if (req_log.size() - base != 1 || req_log[base] !== {1'b0, 16'h0005})
      $display("FAIL dup_req_count: got %0d reqs want 1 read of 0005", req_log.size() - base);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    write = 1'b1; writeaddr = 16'h0009; writedata = 16'h0909;
    tick();
    write = 1'b0;
    tick();
    total_cnt++;
    if (mem_req !== 1'b1) $display("FAIL mid_pre_req: got %b want 1", mem_req); else pass_cnt++;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total_cnt++;
    if ({mem_req, wr_full} !== 2'b00) $display("FAIL mid_req_low: got req=%b full=%b want 0 0", mem_req, wr_full);
    else pass_cnt++;
    mem_ack = 1'b1; mem_rvalid = 1'b1; mem_rdata = 16'hFFFF;
    tick();
    mem_ack = 1'b0; mem_rvalid = 1'b0;
    repeat (3) tick();
    total_cnt++;
    if ({mem_req, err, rd_empty, readdata} !== {1'b0, 2'b00, 1'b1, 16'h0000})
      $display("FAIL mid_stray: got req=%b err=%b empty=%b data=%h want 0 00 1 0000",
               mem_req, err, rd_empty, readdata);
    else pass_cnt++;
    write = 1'b1; writeaddr = 16'h000A; writedata = 16'h0A0A;
    tick();
    write = 1'b0;
    tick();
    total_cnt++;
    if ({mem_req, mem_addr, mem_wdata} !== {1'b1, 16'h000A, 16'h0A0A})
      $display("FAIL mid_fifo_empty: got req=%b addr=%h wd=%h want 1 000a 0a0a", mem_req, mem_addr, mem_wdata);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_fifo_fill();
    test_read_round_trip();
    test_arbitration();
    test_duplicate_read();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
